mlp_input_buffer: RTL and testbench
===================================

# mlp_input_buffer

Ping-pong input-vector buffer directly upstream of the MLP core. It accepts feature words one per cycle over a valid/ready stream and packs NUM_INPUTS of them into a flat vector. Each complete vector is presented to the MLP with a valid/ready handshake; the accept cycle is the MLP's `new_data` pulse. Two banks let the next vector load while the MLP is still consuming the current one.

## Interface
- DATA_WIDTH, 32, width of one feature word
- NUM_INPUTS, 16, words per vector (≥2)
- IDX_W, $clog2(NUM_INPUTS), word-index width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_data  in  DATA_WIDTH  feature word
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final word of a vector
- in_ready  out  1  buffer can accept a word this cycle
- vec_data  out  NUM_INPUTS*DATA_WIDTH  packed vector; word k at [k*DATA_WIDTH +: DATA_WIDTH]
- vec_valid  out  1  vec_data holds a complete vector
- vec_ready  in  1  MLP accepts the vector (vec_valid & vec_ready drives MLP new_data)
- frame_err  out  1  one-cycle pulse: malformed vector discarded
- err_count  out  8  saturating count of discarded vectors
- vecs_held  out  2  number of FULL banks (0..2)

## Operation
- Two banks, each with a state of EMPTY, FILLING or FULL. wr_sel selects the bank being written; rd_sel selects the bank being presented. Both reset to 0.
- in_ready = (bank[wr_sel] != FULL), combinational from registered state.
- Accept condition: in_valid & in_ready.
  - On accept, the word is written at index wr_idx and wr_idx increments.
  - A bank in EMPTY moves to FILLING on its first accept.
- Good close: accept with wr_idx == NUM_INPUTS-1 and in_last=1.
  - Bank becomes FULL, wr_idx returns to 0, wr_sel toggles.
- Short frame: accept with in_last=1 and wr_idx < NUM_INPUTS-1.
  - Bank returns to EMPTY and wr_idx returns to 0; wr_sel does not change.
  - frame_err pulses and err_count increments.
- Long frame: accept with wr_idx == NUM_INPUTS-1 and in_last=0.
  - Handled the same as a short frame.
  - The next accepted word starts a new vector at index 0.
- Presentation: vec_valid = (bank[rd_sel] == FULL). vec_data is muxed from bank rd_sel and is stable while vec_valid is high.
- Release: vec_valid & vec_ready sets bank[rd_sel] to EMPTY and toggles rd_sel.
- vec_data while vec_valid=0 is don't-care; the bench must not check it.
- Simultaneous events:
  - Release of one bank and close of the other bank in the same cycle are both applied.
  - err_count saturates at 255.
  - frame_err and a good close cannot coincide.
- vecs_held equals the number of FULL banks.

## Timing
- Reset values: in_ready=1, vec_valid=0, frame_err=0, err_count=0, vecs_held=0. Bank contents are don't-care; all banks are EMPTY.
- Latency: last word accepted in cycle N gives vec_valid=1 in cycle N+1.
- Release in cycle M:
  - If the other bank is FULL, vec_valid stays 1 in M+1 with the new data.
  - Otherwise vec_valid drops in M+1.
- Throughput: one word per cycle sustained. in_ready goes low only when both banks are FULL, and returns high the cycle after a release.
- vec_valid is never withdrawn without a handshake.
- frame_err is high exactly in cycle N+1 after the offending accept in cycle N.
- Reset asserted mid-fill or mid-presentation discards all data immediately. Outputs take their reset values asynchronously.

## Structure
- Shared package mlp_pkg holds:
  - typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t
  - MLP_DATA_WIDTH and MLP_NUM_INPUTS constants, shared with the MLP core
- Sub-module mlp_vec_bank, instantiated twice:
  - register array of NUM_INPUTS×DATA_WIDTH
  - write port (we, idx, data)
  - flat read output
- The top level holds the bank-state FSMs, pointers, error logic and the output mux.

## Test plan
- NUM_INPUTS=4. Send 1,2,3,4 with in_last on 4 and vec_ready=0 → vec_valid=1 one cycle after the last accept; vec_data={4,3,2,1}; vecs_held=1.
- vec_ready=0. Send two full vectors, then offer a 9th word → in_ready=0 after the 8th accept; vecs_held=2. Pulse vec_ready once → vec_data switches to the second vector and in_ready=1 the next cycle.
- Send 5,6 with in_last on 6 → frame_err pulses one cycle, err_count=1, no vec_valid. The next vector 7,8,9,10 is delivered intact.
- Send 4 words without in_last, then 11,12,13,14 with in_last on 14 → one frame_err; delivered vector is {14,13,12,11}.
- Keep vec_ready=1 and stream 3 back-to-back vectors with in_valid constant → no in_ready deassertion; 3 handshakes delivered in order.
- Assert reset while 2 words of a bank are loaded and one vector is FULL → vec_valid=0, vecs_held=0, in_ready=1. The next full vector is delivered correctly from bank 0.

Source files
------------

// File: rtl/mlp_pkg.sv
// mlp_pkg: definitions shared between the MLP input buffer and the MLP core.
//   bank_state_t   : occupancy state of one input-vector bank
//   MLP_DATA_WIDTH : width of one feature word
//   MLP_NUM_INPUTS : feature words per input vector
package mlp_pkg;

    localparam int unsigned MLP_DATA_WIDTH = 32;
    localparam int unsigned MLP_NUM_INPUTS = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/mlp_vec_bank.sv
// mlp_vec_bank: one bank of the input ping-pong buffer.
//   clk    : clock
//   we_i   : write enable for the word at idx_i
//   idx_i  : word index being written
//   data_i : feature word to store
//   data_o : all NUM_INPUTS words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
// Storage is not reset: contents only matter once the owning FSM marks the bank FULL.
module mlp_vec_bank
    import mlp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MLP_DATA_WIDTH,
    parameter int unsigned NUM_INPUTS = MLP_NUM_INPUTS,
    parameter int unsigned IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             we_i,
    input  logic [IDX_W-1:0]                 idx_i,
    input  logic [DATA_WIDTH-1:0]            data_i,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_INPUTS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= data_i;
        end
    end

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_flat
        assign data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
    end

endmodule

// File: rtl/mlp_input_buffer.sv
// mlp_input_buffer: ping-pong packer of streamed feature words into MLP input vectors.
//   clk, reset        : clock, asynchronous active-high reset
//   in_data_i/valid_i : feature word stream; in_last_i marks the final word of a vector
//   in_ready_o        : a word can be accepted this cycle
//   vec_data_o        : packed vector from the presented bank (word k at k*DATA_WIDTH)
//   vec_valid_o       : presented bank is FULL; vec_valid_o & vec_ready_i is the MLP new_data
//   frame_err_o       : one-cycle pulse after a short or long frame was discarded
//   err_count_o       : saturating count of discarded frames
//   vecs_held_o       : number of FULL banks
module mlp_input_buffer
    import mlp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MLP_DATA_WIDTH,
    parameter int unsigned NUM_INPUTS = MLP_NUM_INPUTS,
    parameter int unsigned IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data_i,
    input  logic                             in_valid_i,
    input  logic                             in_last_i,
    output logic                             in_ready_o,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] vec_data_o,
    output logic                             vec_valid_o,
    input  logic                             vec_ready_i,
    output logic                             frame_err_o,
    output logic [7:0]                       err_count_o,
    output logic [1:0]                       vecs_held_o
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_INPUTS - 1);

    bank_state_t      bank_q [2];
    logic             wr_sel_q;
    logic             rd_sel_q;
    logic [IDX_W-1:0] wr_idx_q;
    logic             frame_err_q;
    logic [7:0]       err_count_q;

    logic [NUM_INPUTS*DATA_WIDTH-1:0] bank0_data;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] bank1_data;

    logic accept;
    logic at_last;
    logic good_close;
    logic bad_close;
    logic release_vec;
    logic bank0_full;
    logic bank1_full;

    assign bank0_full  = (bank_q[0] == FULL);
    assign bank1_full  = (bank_q[1] == FULL);

    assign in_ready_o  = wr_sel_q ? !bank1_full : !bank0_full;
    assign vec_valid_o = rd_sel_q ? bank1_full : bank0_full;
    assign vec_data_o  = rd_sel_q ? bank1_data : bank0_data;
    assign vecs_held_o = {1'b0, bank0_full} + {1'b0, bank1_full};
    assign frame_err_o = frame_err_q;
    assign err_count_o = err_count_q;

    assign accept      = in_valid_i & in_ready_o;
    assign at_last     = (wr_idx_q == LastIdx);
    assign good_close  = accept & at_last & in_last_i;
    // Short frame (last too early) or long frame (no last at the final slot).
    assign bad_close   = accept & (at_last ^ in_last_i);
    assign release_vec = vec_valid_o & vec_ready_i;

    // The written bank is never FULL and the released bank always is, so the
    // write and release updates below never target the same bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_idx_q    <= '0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            frame_err_q <= bad_close;
            if (bad_close && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end

            if (accept) begin
                if (good_close) begin
                    bank_q[wr_sel_q] <= FULL;
                    wr_idx_q         <= '0;
                    wr_sel_q         <= ~wr_sel_q;
                end else if (bad_close) begin
                    bank_q[wr_sel_q] <= EMPTY;
                    wr_idx_q         <= '0;
                end else begin
                    bank_q[wr_sel_q] <= FILLING;
                    wr_idx_q         <= wr_idx_q + 1'b1;
                end
            end

            if (release_vec) begin
                bank_q[rd_sel_q] <= EMPTY;
                rd_sel_q         <= ~rd_sel_q;
            end
        end
    end

    mlp_vec_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_bank0 (
        .clk    (clk),
        .we_i   (accept & ~wr_sel_q),
        .idx_i  (wr_idx_q),
        .data_i (in_data_i),
        .data_o (bank0_data)
    );

    mlp_vec_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_bank1 (
        .clk    (clk),
        .we_i   (accept & wr_sel_q),
        .idx_i  (wr_idx_q),
        .data_i (in_data_i),
        .data_o (bank1_data)
    );

endmodule

// File: tb/tb_mlp_input_buffer.sv
// tb_mlp_input_buffer: directed self-checking bench for mlp_input_buffer with
// NUM_INPUTS=4, DATA_WIDTH=32. Inputs change 1 time unit after the rising edge
// and outputs are sampled there too.
module tb_mlp_input_buffer;

    localparam int unsigned DW = 32;
    localparam int unsigned NI = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [DW-1:0]  in_data_i;
    logic           in_valid_i;
    logic           in_last_i;
    logic           in_ready_o;
    logic [NI*DW-1:0] vec_data_o;
    logic           vec_valid_o;
    logic           vec_ready_i;
    logic           frame_err_o;
    logic [7:0]     err_count_o;
    logic [1:0]     vecs_held_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mlp_input_buffer #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI),
        .IDX_W      (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .vec_data_o  (vec_data_o),
        .vec_valid_o (vec_valid_o),
        .vec_ready_i (vec_ready_i),
        .frame_err_o (frame_err_o),
        .err_count_o (err_count_o),
        .vecs_held_o (vecs_held_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for one cycle; caller knows in_ready is high.
    task automatic send(input int d, input logic l);
        in_valid_i = 1'b1;
        in_data_i  = 32'(d);
        in_last_i  = l;
        step();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic send_vec(input int base, input logic last_on_final);
        send(base,     1'b0);
        send(base + 1, 1'b0);
        send(base + 2, 1'b0);
        send(base + 3, last_on_final);
    endtask

    task automatic release_one();
        vec_ready_i = 1'b1;
        step();
        vec_ready_i = 1'b0;
    endtask

    function automatic logic [127:0] exp_vec(input int base);
        return {32'(base + 3), 32'(base + 2), 32'(base + 1), 32'(base)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        reset       = 1'b1;
        in_data_i   = '0;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        vec_ready_i = 1'b0;

        // Reset values
        #2;
        check("rst_in_ready", in_ready_o, 1);
        check("rst_vec_valid", vec_valid_o, 0);
        check("rst_frame_err", frame_err_o, 0);
        check("rst_err_count", err_count_o, 0);
        check("rst_vecs_held", vecs_held_o, 0);
        step();
        reset = 1'b0;
        step();

        // One vector 1..4, valid exactly one cycle after the last accept
        send(1, 1'b0);
        send(2, 1'b0);
        send(3, 1'b0);
        check("t1_not_early", vec_valid_o, 0);
        send(4, 1'b1);
        check("t1_vec_valid", vec_valid_o, 1);
        check("t1_vec_data", vec_data_o, exp_vec(1));
        check("t1_vecs_held", vecs_held_o, 1);
        check("t1_in_ready", in_ready_o, 1);

        // Second vector fills the other bank; then both full
        send_vec(21, 1'b1);
        check("t2_in_ready_low", in_ready_o, 0);
        check("t2_vecs_held", vecs_held_o, 2);
        check("t2_first_held", vec_data_o, exp_vec(1));
        in_valid_i = 1'b1;
        in_data_i  = 32'd99;
        step();
        check("t2_blocked_ready", in_ready_o, 0);
        check("t2_blocked_held", vecs_held_o, 2);
        vec_ready_i = 1'b1;
        step();
        vec_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        check("t2_switch_valid", vec_valid_o, 1);
        check("t2_switch_data", vec_data_o, exp_vec(21));
        check("t2_ready_back", in_ready_o, 1);
        check("t2_held_one", vecs_held_o, 1);
        release_one();
        check("t2_drained_valid", vec_valid_o, 0);
        check("t2_drained_held", vecs_held_o, 0);

        // Short frame 5,6
        send(5, 1'b0);
        send(6, 1'b1);
        check("t3_frame_err", frame_err_o, 1);
        check("t3_err_count", err_count_o, 1);
        check("t3_no_valid", vec_valid_o, 0);
        check("t3_no_held", vecs_held_o, 0);
        step();
        check("t3_err_one_cycle", frame_err_o, 0);
        send_vec(7, 1'b1);
        check("t3_next_valid", vec_valid_o, 1);
        check("t3_next_data", vec_data_o, exp_vec(7));
        release_one();

        // Long frame followed by a good vector
        send_vec(31, 1'b0);
        check("t4_frame_err", frame_err_o, 1);
        check("t4_err_count", err_count_o, 2);
        check("t4_no_valid", vec_valid_o, 0);
        send_vec(11, 1'b1);
        check("t4_err_cleared", frame_err_o, 0);
        check("t4_valid", vec_valid_o, 1);
        check("t4_data", vec_data_o, exp_vec(11));
        release_one();

        // Back-to-back streaming with vec_ready held high
        got         = 0;
        vec_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'(100 + 10 * (i / 4) + (i % 4));
            in_last_i  = ((i % 4) == 3);
            check("t5_in_ready", in_ready_o, 1);
            if (vec_valid_o) begin
                check("t5_vec_data", vec_data_o, exp_vec(100 + 10 * got));
                got++;
            end
            step();
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (vec_valid_o) begin
                check("t5_vec_data", vec_data_o, exp_vec(100 + 10 * got));
                got++;
            end
            step();
        end
        vec_ready_i = 1'b0;
        check("t5_handshakes", got, 3);
        check("t5_drained", vecs_held_o, 0);

        // Reset with one FULL bank and a partly filled bank
        send_vec(41, 1'b1);
        send(51, 1'b0);
        send(52, 1'b0);
        check("t6_pre_valid", vec_valid_o, 1);
        check("t6_pre_held", vecs_held_o, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", vec_valid_o, 0);
        check("t6_rst_held", vecs_held_o, 0);
        check("t6_rst_ready", in_ready_o, 1);
        check("t6_rst_err_count", err_count_o, 0);
        step();
        reset = 1'b0;
        step();
        send_vec(61, 1'b1);
        check("t6_post_valid", vec_valid_o, 1);
        check("t6_post_data", vec_data_o, exp_vec(61));
        check("t6_post_held", vecs_held_o, 1);
        release_one();
        check("t6_post_drained", vec_valid_o, 0);

        // err_count saturates at 255
        for (int i = 0; i < 256; i++) begin
            send(200 + i, 1'b1);
        end
        check("t7_err_pulse", frame_err_o, 1);
        check("t7_err_sat", err_count_o, 255);
        step();
        check("t7_err_idle", frame_err_o, 0);
        check("t7_err_hold", err_count_o, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
